// File: rtl/debug_run_ctrl.sv
// Run-control stage on the system clock: takes HALT/RESUME/STEP requests from the
// JTAG side over a toggle handshake and drives pipeline stall and scan-enable.
module debug_run_ctrl #(
    parameter int SYNC_STAGES  = 2,
    parameter int CNT_W        = 16,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_tog,
    input  logic [1:0]       cmd,
    input  logic [CNT_W-1:0] arg,
    output logic             ack_tog,
    input  logic             retired,
    output logic             halt_req,
    output logic             scan_en,
    output logic             busy,
    output logic [1:0]       status
);

    localparam int DRAIN_W = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [CNT_W-1:0]   STEP_ONE   = CNT_W'(1);
    localparam logic [1:0] CMD_HALT   = 2'd1;
    localparam logic [1:0] CMD_RESUME = 2'd2;
    localparam logic [1:0] CMD_STEP   = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_HALTING  = 2'b01,
        ST_HALTED   = 2'b10,
        ST_STEPPING = 2'b11
    } state_t;

    state_t                 state_r, state_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic [DRAIN_W-1:0]     drain_r, drain_s;
    logic [CNT_W-1:0]       step_r, step_s;
    logic                   ack_s, halt_s, scan_s, busy_s;
    logic                   req_s, is_halt_s, is_resume_s, is_step_s;

    // Request detect: the synchronized toggle differs from its last sampled value.
    assign req_s       = sync_r[SYNC_STAGES-1] ^ prev_r;
    assign is_halt_s   = req_s && (cmd == CMD_HALT);
    assign is_resume_s = req_s && (cmd == CMD_RESUME);
    assign is_step_s   = req_s && (cmd == CMD_STEP);
    assign status      = state_r;

    // Synchronizer, state register and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_r   <= '0;
            prev_r   <= 1'b0;
            state_r  <= ST_RUN;
            drain_r  <= '0;
            step_r   <= '0;
            ack_tog  <= 1'b0;
            halt_req <= 1'b0;
            scan_en  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            sync_r   <= {sync_r[SYNC_STAGES-2:0], req_tog};
            prev_r   <= sync_r[SYNC_STAGES-1];
            state_r  <= state_s;
            drain_r  <= drain_s;
            step_r   <= step_s;
            ack_tog  <= ack_s;
            halt_req <= halt_s;
            scan_en  <= scan_s;
            busy     <= busy_s;
        end
    end

    // Next-state logic; a command taking effect masks a same-cycle retired pulse.
    always_comb begin
        state_s = state_r;
        drain_s = drain_r;
        step_s  = step_r;
        ack_s   = ack_tog ^ req_s;
        case (state_r)
            ST_RUN: begin
                if (is_halt_s) begin
                    state_s = ST_HALTING;
                    drain_s = DRAIN_INIT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_HALTING: begin
                if (is_resume_s) begin
                    state_s = ST_RUN;
                    drain_s = '0;
                end else if (drain_r == '0) begin
                    state_s = ST_HALTED;
                end else begin
                    drain_s = drain_r - DRAIN_ONE;
                end
            end
            ST_HALTED: begin
                if (is_resume_s) begin
                    state_s = ST_RUN;
                end else if (is_step_s && (arg != '0)) begin
                    state_s = ST_STEPPING;
                    step_s  = arg;
                end else begin
                    state_s = ST_HALTED;
                end
            end
            ST_STEPPING: begin
                if (is_halt_s) begin
                    state_s = ST_HALTING;
                    drain_s = DRAIN_INIT;
                    step_s  = '0;
                end else if (is_resume_s) begin
                    state_s = ST_RUN;
                    step_s  = '0;
                end else if (retired && (step_r == STEP_ONE)) begin
                    state_s = ST_HALTING;
                    drain_s = DRAIN_INIT;
                    step_s  = '0;
                end else if (retired && (step_r != '0)) begin
                    step_s = step_r - STEP_ONE;
                end else begin
                    state_s = ST_STEPPING;
                end
            end
            default: begin
                state_s = ST_RUN;
                drain_s = '0;
                step_s  = '0;
            end
        endcase
        halt_s = (state_s == ST_HALTING) || (state_s == ST_HALTED);
        scan_s = (state_s == ST_HALTED);
        busy_s = (state_s == ST_HALTING) || (state_s == ST_STEPPING);
    end

endmodule
